// File: rtl/uart_fpu_ctrl.sv
// uart_fpu_ctrl
//   Collects two operand words (A and B) from an upstream receiver. When both
//   are present it issues one start pulse to a floating-point unit, then waits
//   a bounded time for the result. The result is streamed MSB-first, one byte
//   per cycle, into a UART TX FIFO that may apply backpressure.
//
// Ports
//   i_clk          single clock, rising edge
//   i_rst_n        synchronous active-low reset
//   i_done_a/b     one-cycle operand-valid pulses, with i_data_a/b words
//   i_op           FPU operation code, latched when the operand pair completes
//   i_fpu_done     one-cycle result-valid pulse, with i_fpu_result
//   i_tx_full      TX FIFO full; holds off byte writes
//   o_fpu_start    one-cycle start pulse to the FPU
//   o_fpu_a/b/op   registered operands and operation code
//   o_tx_wr_en     TX FIFO write strobe, with o_tx_data byte
//   o_busy         high whenever not collecting operands
//   o_err_timeout  FPU did not answer in time (cleared by the next start)
//   o_err_overrun  operand arrived while busy (cleared only by reset)
module uart_fpu_ctrl #(
  parameter int SIZE_DATA = 32,
  parameter int SIZE_BYTE = 8,
  parameter int TIMEOUT   = 1024
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_done_a,
  input  logic [SIZE_DATA-1:0] i_data_a,
  input  logic                 i_done_b,
  input  logic [SIZE_DATA-1:0] i_data_b,
  input  logic [1:0]           i_op,
  input  logic                 i_fpu_done,
  input  logic [SIZE_DATA-1:0] i_fpu_result,
  input  logic                 i_tx_full,
  output logic                 o_fpu_start,
  output logic [SIZE_DATA-1:0] o_fpu_a,
  output logic [SIZE_DATA-1:0] o_fpu_b,
  output logic [1:0]           o_fpu_op,
  output logic                 o_tx_wr_en,
  output logic [SIZE_BYTE-1:0] o_tx_data,
  output logic                 o_busy,
  output logic                 o_err_timeout,
  output logic                 o_err_overrun
);

  localparam int NUM_BYTES = SIZE_DATA / SIZE_BYTE;
  localparam int IDX_W     = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1;
  localparam int CNT_W     = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    COLLECT  = 2'd0,
    START    = 2'd1,
    WAIT_FPU = 2'd2,
    SEND     = 2'd3
  } state_t;

  state_t               state;
  logic                 flag_a;
  logic                 flag_b;
  logic [CNT_W-1:0]     count;
  logic [IDX_W-1:0]     idx;
  logic [SIZE_DATA-1:0] result;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state         <= COLLECT;
      flag_a        <= 1'b0;
      flag_b        <= 1'b0;
      count         <= '0;
      idx           <= '0;
      result        <= '0;
      o_fpu_a       <= '0;
      o_fpu_b       <= '0;
      o_fpu_op      <= '0;
      o_err_timeout <= 1'b0;
      o_err_overrun <= 1'b0;
    end else begin
      // Operand pulses are only legal while collecting; anywhere else the
      // word is dropped and the sticky overrun flag records the loss.
      if ((i_done_a || i_done_b) && (state != COLLECT))
        o_err_overrun <= 1'b1;

      case (state)
        COLLECT: begin
          // A later pulse for the same operand simply replaces the held word.
          if (i_done_a) begin
            o_fpu_a <= i_data_a;
            flag_a  <= 1'b1;
          end
          if (i_done_b) begin
            o_fpu_b <= i_data_b;
            flag_b  <= 1'b1;
          end
          // The pair is complete only once both flags are registered, so the
          // start is issued one cycle after the second word lands.
          if (flag_a && flag_b) begin
            o_fpu_op <= i_op;
            flag_a   <= 1'b0;
            flag_b   <= 1'b0;
            state    <= START;
          end
        end

        START: begin
          o_err_timeout <= 1'b0;
          count         <= '0;
          state         <= WAIT_FPU;
        end

        WAIT_FPU: begin
          if (i_fpu_done) begin
            result <= i_fpu_result;
            idx    <= IDX_W'(NUM_BYTES - 1);
            state  <= SEND;
          end else if (count == CNT_W'(TIMEOUT - 1)) begin
            o_err_timeout <= 1'b1;
            state         <= COLLECT;
          end else begin
            count <= count + CNT_W'(1);
          end
        end

        SEND: begin
          if (!i_tx_full) begin
            if (idx == '0)
              state <= COLLECT;
            else
              idx <= idx - IDX_W'(1);
          end
        end

        default: state <= COLLECT;
      endcase
    end
  end

  // Strobes are decoded from the state register and gated by reset so that
  // a reset arriving mid-operation cannot leak one more pulse or write.
  always_comb begin
    o_fpu_start = i_rst_n && (state == START);
    o_tx_wr_en  = i_rst_n && (state == SEND) && !i_tx_full;
    o_busy      = (state != COLLECT);
    o_tx_data   = result[idx*SIZE_BYTE +: SIZE_BYTE];
  end

endmodule

// File: tb/tb_uart_fpu_ctrl.sv
// tb_uart_fpu_ctrl
//   Directed bench for uart_fpu_ctrl. Stimulus pushes the expected start
//   operands and expected TX bytes into scoreboard queues; an independent
//   monitor pops and compares whenever the DUT strobes o_fpu_start or
//   o_tx_wr_en. Any strobe with nothing queued is reported as unexpected.
module tb_uart_fpu_ctrl;

  localparam int TO = 16;

  logic        i_clk = 1'b0;
  logic        i_rst_n;
  logic        i_done_a;
  logic [31:0] i_data_a;
  logic        i_done_b;
  logic [31:0] i_data_b;
  logic [1:0]  i_op;
  logic        i_fpu_done;
  logic [31:0] i_fpu_result;
  logic        i_tx_full;
  logic        o_fpu_start;
  logic [31:0] o_fpu_a;
  logic [31:0] o_fpu_b;
  logic [1:0]  o_fpu_op;
  logic        o_tx_wr_en;
  logic [7:0]  o_tx_data;
  logic        o_busy;
  logic        o_err_timeout;
  logic        o_err_overrun;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic [1:0]  op;
  } start_t;

  start_t     exp_start_q[$];
  logic [7:0] exp_tx_q[$];
  start_t     mon_s;
  logic [7:0] mon_byte;

  int total = 0;
  int bad   = 0;

  uart_fpu_ctrl #(
    .SIZE_DATA(32),
    .SIZE_BYTE(8),
    .TIMEOUT  (TO)
  ) dut (
    .i_clk        (i_clk),
    .i_rst_n      (i_rst_n),
    .i_done_a     (i_done_a),
    .i_data_a     (i_data_a),
    .i_done_b     (i_done_b),
    .i_data_b     (i_data_b),
    .i_op         (i_op),
    .i_fpu_done   (i_fpu_done),
    .i_fpu_result (i_fpu_result),
    .i_tx_full    (i_tx_full),
    .o_fpu_start  (o_fpu_start),
    .o_fpu_a      (o_fpu_a),
    .o_fpu_b      (o_fpu_b),
    .o_fpu_op     (o_fpu_op),
    .o_tx_wr_en   (o_tx_wr_en),
    .o_tx_data    (o_tx_data),
    .o_busy       (o_busy),
    .o_err_timeout(o_err_timeout),
    .o_err_overrun(o_err_overrun)
  );

  always #5 i_clk = ~i_clk;

  task automatic checkOutput(input string name, input logic [31:0] act,
                             input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic noteUnexpected(input string name, input logic [31:0] act);
    total++;
    bad++;
    $display("[TB] FAIL %s: got %h expected nothing", name, act);
  endtask

  // Drive one cycle of operand pulses, then clear them.
  task automatic applyStimulus(input logic da, input logic [31:0] a,
                               input logic db, input logic [31:0] b);
    i_done_a = da;
    i_data_a = a;
    i_done_b = db;
    i_data_b = b;
    @(posedge i_clk);
    #1;
    i_done_a = 1'b0;
    i_done_b = 1'b0;
  endtask

  // Pulse the FPU result and queue the bytes expected on the TX side.
  task automatic fpuDone(input logic [31:0] r, input int nbytes);
    for (int k = 3; k > 3 - nbytes; k--)
      exp_tx_q.push_back(r[k*8 +: 8]);
    @(posedge i_clk);
    #1;
    i_fpu_done   = 1'b1;
    i_fpu_result = r;
    @(posedge i_clk);
    #1;
    i_fpu_done = 1'b0;
  endtask

  task automatic expectStart(input logic [31:0] a, input logic [31:0] b,
                             input logic [1:0] op);
    start_t s;
    s.a  = a;
    s.b  = b;
    s.op = op;
    exp_start_q.push_back(s);
  endtask

  task automatic waitStart();
    logic found;
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      @(negedge i_clk);
      if (o_fpu_start) found = 1'b1;
    end
    checkOutput("start_seen", {31'b0, found}, 32'd1);
  endtask

  task automatic waitIdle();
    for (int i = 0; i < 60 && o_busy; i++)
      @(negedge i_clk);
    checkOutput("idle_reached", {31'b0, o_busy}, 32'd0);
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_fpu_a"}, o_fpu_a, 32'd0);
    checkOutput({tag, "_fpu_b"}, o_fpu_b, 32'd0);
    checkOutput({tag, "_fpu_op"}, {30'b0, o_fpu_op}, 32'd0);
    checkOutput({tag, "_busy"}, {31'b0, o_busy}, 32'd0);
    checkOutput({tag, "_timeout"}, {31'b0, o_err_timeout}, 32'd0);
    checkOutput({tag, "_overrun"}, {31'b0, o_err_overrun}, 32'd0);
    checkOutput({tag, "_start"}, {31'b0, o_fpu_start}, 32'd0);
    checkOutput({tag, "_wr_en"}, {31'b0, o_tx_wr_en}, 32'd0);
  endtask

  // Monitor: every start or TX write must match the head of its queue.
  always @(negedge i_clk) begin
    if (o_fpu_start) begin
      if (exp_start_q.size() == 0) begin
        noteUnexpected("unexpected_start", o_fpu_a);
      end else begin
        mon_s = exp_start_q.pop_front();
        checkOutput("start_a", o_fpu_a, mon_s.a);
        checkOutput("start_b", o_fpu_b, mon_s.b);
        checkOutput("start_op", {30'b0, o_fpu_op}, {30'b0, mon_s.op});
      end
    end
    if (o_tx_wr_en) begin
      checkOutput("wr_while_full", {31'b0, i_tx_full}, 32'd0);
      if (exp_tx_q.size() == 0) begin
        noteUnexpected("unexpected_tx", {24'b0, o_tx_data});
      end else begin
        mon_byte = exp_tx_q.pop_front();
        checkOutput("tx_byte", {24'b0, o_tx_data}, {24'b0, mon_byte});
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int  n;
    logic in_window;
    i_rst_n      = 1'b0;
    i_done_a     = 1'b0;
    i_data_a     = '0;
    i_done_b     = 1'b0;
    i_data_b     = '0;
    i_op         = 2'd0;
    i_fpu_done   = 1'b0;
    i_fpu_result = '0;
    i_tx_full    = 1'b0;
    repeat (3) @(posedge i_clk);
    #1;
    i_rst_n = 1'b1;
    @(negedge i_clk);
    checkAllZero("reset");

    $display("[TB] basic");
    i_op = 2'd1;
    expectStart(32'h11223344, 32'hAABBCCDD, 2'd1);
    applyStimulus(1'b1, 32'h11223344, 1'b0, 32'h0);
    applyStimulus(1'b0, 32'h0, 1'b1, 32'hAABBCCDD);
    waitStart();
    fpuDone(32'h3F800000, 4);
    for (int i = 0; i < 4; i++) begin
      @(negedge i_clk);
      checkOutput("basic_wr_consecutive", {31'b0, o_tx_wr_en}, 32'd1);
    end
    @(negedge i_clk);
    checkOutput("basic_wr_after", {31'b0, o_tx_wr_en}, 32'd0);
    checkOutput("basic_busy_after", {31'b0, o_busy}, 32'd0);

    $display("[TB] order B then A");
    i_op = 2'd2;
    expectStart(32'h01020304, 32'h05060708, 2'd2);
    applyStimulus(1'b0, 32'h0, 1'b1, 32'h05060708);
    applyStimulus(1'b1, 32'h01020304, 1'b0, 32'h0);
    waitStart();
    fpuDone(32'hC0000000, 4);
    waitIdle();

    $display("[TB] simultaneous");
    i_op = 2'd3;
    expectStart(32'h40400000, 32'hBF000000, 2'd3);
    applyStimulus(1'b1, 32'h40400000, 1'b1, 32'hBF000000);
    waitStart();
    fpuDone(32'h3FC00000, 4);
    waitIdle();

    $display("[TB] backpressure");
    i_op = 2'd0;
    expectStart(32'h3F800000, 32'h00000000, 2'd0);
    applyStimulus(1'b1, 32'h3F800000, 1'b1, 32'h00000000);
    waitStart();
    fpuDone(32'h3F800000, 4);
    @(posedge i_clk);
    #1;
    i_tx_full = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge i_clk);
      checkOutput("bp_no_write", {31'b0, o_tx_wr_en}, 32'd0);
      @(posedge i_clk);
      #1;
    end
    i_tx_full = 1'b0;
    waitIdle();
    checkOutput("overrun_before", {31'b0, o_err_overrun}, 32'd0);

    $display("[TB] timeout");
    i_op = 2'd1;
    expectStart(32'h12121212, 32'h34343434, 2'd1);
    applyStimulus(1'b1, 32'h12121212, 1'b1, 32'h34343434);
    waitStart();
    n = 0;
    for (int i = 0; i < 4 * TO && !o_err_timeout; i++) begin
      @(negedge i_clk);
      n++;
    end
    in_window = (n >= TO) && (n <= TO + 2);
    $display("[TB] timeout flag seen %0d cycles after start", n);
    checkOutput("timeout_flag", {31'b0, o_err_timeout}, 32'd1);
    checkOutput("timeout_latency_window", {31'b0, in_window}, 32'd1);
    checkOutput("timeout_busy", {31'b0, o_busy}, 32'd0);
    expectStart(32'h56565656, 32'h78787878, 2'd1);
    applyStimulus(1'b1, 32'h56565656, 1'b1, 32'h78787878);
    waitStart();
    @(negedge i_clk);
    checkOutput("timeout_cleared", {31'b0, o_err_timeout}, 32'd0);
    fpuDone(32'h40490FDB, 4);
    waitIdle();

    $display("[TB] overrun");
    i_op = 2'd2;
    expectStart(32'hCAFEF00D, 32'h0BADBEEF, 2'd2);
    applyStimulus(1'b1, 32'hCAFEF00D, 1'b1, 32'h0BADBEEF);
    waitStart();
    @(posedge i_clk);
    #1;
    applyStimulus(1'b1, 32'hDEADBEEF, 1'b0, 32'h0);
    @(negedge i_clk);
    checkOutput("overrun_flag", {31'b0, o_err_overrun}, 32'd1);
    checkOutput("overrun_a_kept", o_fpu_a, 32'hCAFEF00D);
    fpuDone(32'h41200000, 4);
    waitIdle();
    checkOutput("overrun_sticky", {31'b0, o_err_overrun}, 32'd1);

    $display("[TB] reset mid-send");
    i_op = 2'd3;
    expectStart(32'h9ABCDEF0, 32'h0FEDCBA9, 2'd3);
    applyStimulus(1'b1, 32'h9ABCDEF0, 1'b1, 32'h0FEDCBA9);
    waitStart();
    fpuDone(32'h12345678, 2);
    @(posedge i_clk);
    #1;
    @(posedge i_clk);
    #1;
    i_rst_n = 1'b0;
    @(posedge i_clk);
    #1;
    i_rst_n = 1'b1;
    @(negedge i_clk);
    checkAllZero("midreset");
    repeat (5) @(negedge i_clk);
    i_op = 2'd1;
    expectStart(32'h3F800000, 32'h40000000, 2'd1);
    applyStimulus(1'b0, 32'h0, 1'b1, 32'h40000000);
    applyStimulus(1'b1, 32'h3F800000, 1'b0, 32'h0);
    waitStart();
    fpuDone(32'h40400000, 4);
    waitIdle();

    repeat (3) @(negedge i_clk);
    checkOutput("start_queue_drained", exp_start_q.size(), 32'd0);
    checkOutput("tx_queue_drained", exp_tx_q.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/uart_fpu_ctrl.md
UART_FPU_CTRL -- requirements
Module: uart_fpu_ctrl

Interface
Parameters:
REQ-001 The block SHALL provide parameter SIZE_DATA, default 32, the operand and result width.
REQ-002 The block SHALL provide parameter SIZE_BYTE, default 8, the UART byte width.
REQ-003 The block SHALL provide parameter TIMEOUT, default 1024, the maximum cycles to wait for FPU completion.
Ports:
REQ-004 The block SHALL have port i_clk, input, 1 bit: the single clock; all logic on its rising edge.
REQ-005 The block SHALL have port i_rst_n, input, 1 bit: reset, synchronous, active-low.
REQ-006 The block SHALL have port i_done_a, input, 1 bit: one-cycle pulse, operand A word valid.
REQ-007 The block SHALL have port i_data_a, input, SIZE_DATA bits: operand A word.
REQ-008 The block SHALL have port i_done_b, input, 1 bit: one-cycle pulse, operand B word valid.
REQ-009 The block SHALL have port i_data_b, input, SIZE_DATA bits: operand B word.
REQ-010 The block SHALL have port i_op, input, 2 bits: FPU operation code.
REQ-011 The block SHALL have port i_fpu_done, input, 1 bit: one-cycle pulse, result valid.
REQ-012 The block SHALL have port i_fpu_result, input, SIZE_DATA bits: FPU result.
REQ-013 The block SHALL have port i_tx_full, input, 1 bit: UART TX FIFO full.
REQ-014 The block SHALL have port o_fpu_start, output, 1 bit: one-cycle start pulse.
REQ-015 The block SHALL have ports o_fpu_a and o_fpu_b, output, SIZE_DATA bits each: registered operands.
REQ-016 The block SHALL have port o_fpu_op, output, 2 bits: registered operation code.
REQ-017 The block SHALL have port o_tx_wr_en, output, 1 bit: TX FIFO write strobe.
REQ-018 The block SHALL have port o_tx_data, output, SIZE_BYTE bits: byte to transmit.
REQ-019 The block SHALL have port o_busy, output, 1 bit: high in every state except COLLECT.
REQ-020 The block SHALL have port o_err_timeout, output, 1 bit: sticky timeout flag.
REQ-021 The block SHALL have port o_err_overrun, output, 1 bit: sticky operand-overrun flag.

Function
REQ-022 States SHALL be COLLECT, START, WAIT_FPU, SEND; next-state SHALL be registered.
REQ-023 COLLECT: on i_done_a, o_fpu_a <= i_data_a and flag_a set; on i_done_b, o_fpu_b <= i_data_b and flag_b set.
- Arrival order: any.
- Same-cycle pulses: both captured.
- Repeated pulse before the pair completes: overwrites the held word, no error.
REQ-024 Move from COLLECT to START on the cycle after both flags are set; on that edge, i_op latched into o_fpu_op and both flags cleared.
REQ-025 START SHALL last exactly one cycle with o_fpu_start=1; o_err_timeout cleared; next state WAIT_FPU.
REQ-026 WAIT_FPU SHALL count cycles from 0.
- On i_fpu_done: result captured, byte index set to 3, go to SEND.
- Count reaching TIMEOUT without i_fpu_done: set o_err_timeout, go to COLLECT, transmit nothing.
REQ-027 SEND SHALL transmit the result MSB first: bytes [31:24], [23:16], [15:8], [7:0].
REQ-028 In SEND with i_tx_full=0: o_tx_wr_en=1 and o_tx_data=current byte (combinational from index), index decrements.
REQ-029 In SEND with i_tx_full=1: o_tx_wr_en=0, index held; stall length unbounded.
REQ-030 After the byte at index 0 is written, next state SHALL be COLLECT; unstalled SEND lasts exactly 4 cycles.
REQ-031 i_done_a/i_done_b in any state other than COLLECT SHALL be ignored (word not captured) and SHALL set o_err_overrun.
- o_err_overrun clears only on reset.
REQ-032 i_fpu_done outside WAIT_FPU SHALL be ignored.
REQ-033 o_tx_wr_en SHALL be 0 outside SEND; o_fpu_start SHALL be 0 outside START.

Reset
REQ-034 When i_rst_n=0 at a rising edge, the following SHALL apply from the next cycle:
- state=COLLECT; flags, counter and index cleared.
- Outputs all 0: o_fpu_a, o_fpu_b, o_fpu_op, o_busy, o_err_timeout, o_err_overrun, o_fpu_start, o_tx_wr_en.
REQ-035 Reset mid-operation (any state) SHALL abort without further start pulses or TX writes.

Verification
REQ-036 Bench SHALL cover these directed scenarios:
- Basic: A=0x11223344 then B=0xAABBCCDD, i_op=1 -> one o_fpu_start with a/b/op matching; fpu_done with result 0x3F800000 -> TX bytes 3F,80,00,00 on 4 consecutive cycles; o_busy falls after.
- Order/simultaneous: B pulse first, then A; then both pulses in one cycle -> each pair yields exactly one start with correct words.
- Backpressure: i_tx_full=1 for 5 cycles after first byte -> bytes still 3F,80,00,00 exactly once each; no write while full.
- Timeout: no i_fpu_done -> o_err_timeout=1 at TIMEOUT cycles after start, no TX writes; next start clears it.
- Overrun: i_done_a during WAIT_FPU -> o_err_overrun=1, o_fpu_a unchanged.
- Reset mid-SEND after 2 bytes -> no further o_tx_wr_en; all outputs 0; a new operand pair works normally.
